// File: rtl/fp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// fp_pkg : binary32 field widths, constants and divider FSM states
// Rev 1.0
// ----------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int BIAS      = 127;
  localparam int DIV_STEPS = 25;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_div_iter.sv
`default_nettype none
// ----------------------------------------------------------------------
// fp_div_iter : 25-step restoring mantissa divider (one quotient bit/cycle)
// Rev 1.0
// ----------------------------------------------------------------------
module fp_div_iter
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MANT_W:0]      dividend,
  input  logic [MANT_W:0]      divisor,
  output logic                 done,
  output logic [DIV_STEPS-1:0] quotient
);

  logic [DIV_STEPS-1:0] rem;
  logic [MANT_W:0]      dsr;
  logic [4:0]           cnt;
  logic                 busy;
  logic                 rem_ge;
  logic [DIV_STEPS-1:0] rem_diff;

  assign rem_ge   = rem >= {1'b0, dsr};
  assign rem_diff = rem - {1'b0, dsr};
  // Pulses during the final iteration so the FSM leaves DIVIDE on that edge.
  assign done     = busy && (cnt == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem      <= {1'b0, dividend};
      dsr      <= divisor;
      cnt      <= 5'(DIV_STEPS - 1);
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      // Remainder stays below 2*divisor, so the shifted value fits in 25 bits.
      if (rem_ge) begin
        quotient[cnt] <= 1'b1;
        rem           <= {rem_diff[DIV_STEPS-2:0], 1'b0};
      end else begin
        rem           <= {rem[DIV_STEPS-2:0], 1'b0};
      end
      if (cnt == 5'd0) busy <= 1'b0;
      else             cnt  <= cnt - 5'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_divider.sv
`default_nettype none
// ----------------------------------------------------------------------
// fp_divider : sequential binary32 divider, truncating, denormals as zero
// Rev 1.0
// ----------------------------------------------------------------------
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  state_t             state;
  logic               sign;
  logic [EXP_W-1:0]   ea;
  logic [EXP_W-1:0]   eb;

  logic [EXP_W-1:0]   a_exp;
  logic [EXP_W-1:0]   b_exp;
  logic               in_sign;
  logic               accept;
  logic               special;
  logic [31:0]        special_res;
  logic               special_dbz;

  logic               iter_done;
  logic [DIV_STEPS-1:0] quot;

  logic signed [9:0]  norm_exp;
  logic [MANT_W-1:0]  norm_mant;
  logic               norm_ovf;
  logic               norm_unf;
  logic [31:0]        norm_res;

  assign a_exp   = a[30:23];
  assign b_exp   = b[30:23];
  assign in_sign = a[31] ^ b[31];
  assign accept  = in_valid && in_ready && (state == IDLE);

  // Ordering matters: 0/0 beats x/0, which beats the zero/inf-divisor cases.
  always_comb begin
    special     = 1'b1;
    special_res = '0;
    special_dbz = 1'b0;
    if (a_exp == '0 && b_exp == '0) begin
      special_res = FP_QNAN;
    end else if (b_exp == '0) begin
      special_res = {in_sign, FP_INF_MAG};
      special_dbz = 1'b1;
    end else if (a_exp == '0 || b_exp == '1) begin
      special_res = {in_sign, 31'h0};
    end else if (a_exp == '1) begin
      special_res = {in_sign, FP_INF_MAG};
    end else begin
      special     = 1'b0;
    end
  end

  fp_div_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && !special),
    .dividend ({1'b1, a[MANT_W-1:0]}),
    .divisor  ({1'b1, b[MANT_W-1:0]}),
    .done     (iter_done),
    .quotient (quot)
  );

  always_comb begin
    norm_exp  = 10'({2'b00, ea}) - 10'({2'b00, eb})
              + (quot[DIV_STEPS-1] ? 10'(BIAS) : 10'(BIAS - 1));
    norm_mant = quot[DIV_STEPS-1] ? quot[MANT_W:1] : quot[MANT_W-1:0];
    norm_ovf  = norm_exp >= 10'sd255;
    norm_unf  = norm_exp <= 10'sd0;
    if (norm_ovf)      norm_res = {sign, FP_INF_MAG};
    else if (norm_unf) norm_res = {sign, 31'h0};
    else               norm_res = {sign, norm_exp[EXP_W-1:0], norm_mant};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      sign        <= 1'b0;
      ea          <= '0;
      eb          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign     <= in_sign;
            ea       <= a_exp;
            eb       <= b_exp;
            in_ready <= 1'b0;
            if (special) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              result      <= special_res;
              div_by_zero <= special_dbz;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (iter_done) state <= NORM;
        end
        NORM: begin
          state     <= DONE;
          out_valid <= 1'b1;
          result    <= norm_res;
          overflow  <= norm_ovf;
          underflow <= norm_unf;
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------
// tb_fp_divider : scoreboard bench for fp_divider
// Rev 1.0
// ----------------------------------------------------------------------
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  always #5 clk = ~clk;

  fp_divider dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result      (result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    logic        unf;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a negedge; cycle 1 is the negedge right after the input handshake.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] res, input logic dbz, input logic ovf,
                        input logic unf, input int lat, input int hold);
    int          n;
    exp_t        x;
    logic [31:0] held;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    sb.push_back(exp_t'{res, dbz, ovf, unf, 8'(lat)});
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check("latency", 32'(n), 32'(x.lat));
      check("result", result, x.res);
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, x.dbz});
      check("overflow", {31'b0, overflow}, {31'b0, x.ovf});
      check("underflow", {31'b0, underflow}, {31'b0, x.unf});
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        a        = 32'h3F800000;
        b        = 32'h00000000;
        in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(negedge clk);
      check("bp_result", result, held);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_cleared", {31'b0, out_valid}, 32'd0);
    check("in_ready_back", {31'b0, in_ready}, 32'd1);
    check("result_cleared", result, 32'd0);
    if (hold > 0) begin
      repeat (3) @(negedge clk);
      check("ignored_pair", {31'b0, out_valid}, 32'd0);
      check("ignored_ready", {31'b0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'b0, div_by_zero, overflow, underflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal path
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27, 0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 0, 27, 0);
    run_op(32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 0, 0, 0, 27, 0);
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 0, 27, 0);
    run_op(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 0, 0, 0, 27, 0);
    // Specials
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 0, 1, 0);
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 1, 0, 0, 1, 0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 0, 0, 0, 1, 0);
    run_op(32'h80000000, 32'h80000000, 32'h7FC00000, 0, 0, 0, 1, 0);
    run_op(32'h00000000, 32'h40000000, 32'h00000000, 0, 0, 0, 1, 0);
    run_op(32'h80000000, 32'h40000000, 32'h80000000, 0, 0, 0, 1, 0);
    run_op(32'h7F800000, 32'h40000000, 32'h7F800000, 0, 0, 0, 1, 0);
    run_op(32'h40000000, 32'h7F800000, 32'h00000000, 0, 0, 0, 1, 0);
    // Exponent limits and their boundaries
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 0, 1, 0, 27, 0);
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 0, 0, 1, 27, 0);
    run_op(32'h7F000000, 32'h3F000000, 32'h7F800000, 0, 1, 0, 27, 0);
    run_op(32'h7F000000, 32'h3F800000, 32'h7F000000, 0, 0, 0, 27, 0);
    run_op(32'h00800000, 32'h3F800000, 32'h00800000, 0, 0, 0, 27, 0);
    run_op(32'h00800000, 32'h40000000, 32'h00000000, 0, 0, 1, 27, 0);
    // Backpressure with an ignored second request
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27, 10);

    // Reset in the middle of a division
    a        = 32'h7F000000;
    b        = 32'h00800000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
